// File: rtl/conv_rr_arbiter.sv
// Round-robin owner of a single conv engine: one requester holds the engine for a
// full vector load plus its complete result drain, with zero-latency handshake muxing.
//
// state | meaning
// IDLE  | no owner; pick the first valid requester at or after ptr
// LOAD  | owner's x stream wired to engine until X samples accepted
// DRAIN | engine y stream wired to owner until X-F+1 results delivered
module conv_rr_arbiter #(
  parameter int N = 4,
  parameter int X = 32,
  parameter int F = 4,
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N*W-1:0] req_x_data,
  input  logic [N-1:0]   req_x_valid,
  output logic [N-1:0]   req_x_ready,
  output logic [N*W-1:0] req_y_data,
  output logic [N-1:0]   req_y_valid,
  input  logic [N-1:0]   req_y_ready,
  output logic [W-1:0]   eng_x_data,
  output logic           eng_x_valid,
  input  logic           eng_x_ready,
  input  logic [W-1:0]   eng_y_data,
  input  logic           eng_y_valid,
  output logic           eng_y_ready,
  output logic [N-1:0]   grant,
  output logic           busy
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(X);
  localparam logic [GW:0]   N_V    = (GW+1)'(N);
  localparam logic [GW-1:0] G_LAST = GW'(N - 1);
  localparam logic [CW-1:0] X_LAST = CW'(X - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(X - F);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [GW-1:0] ptr;
  logic [GW-1:0] gidx;
  logic [CW-1:0] xcnt;
  logic [CW-1:0] ycnt;

  logic          win_found;
  logic [GW-1:0] win_idx;
  logic [GW:0]   cand;
  logic          x_fire;
  logic          y_fire;

  // Rotating search: candidate index is ptr+k folded back into 0..N-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (GW+1)'(k);
      if (cand >= N_V) cand = cand - N_V;
      if (!win_found && req_x_valid[cand[GW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[GW-1:0];
      end
    end
  end

  always_comb begin
    eng_x_data  = '0;
    eng_x_valid = 1'b0;
    eng_y_ready = 1'b0;
    req_x_ready = '0;
    req_y_data  = '0;
    req_y_valid = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        if (state == LOAD) begin
          eng_x_data     = req_x_data[i*W +: W];
          eng_x_valid    = req_x_valid[i];
          req_x_ready[i] = eng_x_ready;
        end
        if (state == DRAIN) begin
          req_y_data[i*W +: W] = eng_y_data;
          req_y_valid[i]       = eng_y_valid;
          eng_y_ready          = req_y_ready[i];
        end
      end
    end
  end

  assign x_fire = eng_x_valid & eng_x_ready;
  assign y_fire = eng_y_valid & eng_y_ready;

  // Counters hold at their terminal value; the state change is what ends each phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      busy  <= 1'b0;
      ptr   <= '0;
      gidx  <= '0;
      xcnt  <= '0;
      ycnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_found) begin
            grant <= N'(1) << win_idx;
            gidx  <= win_idx;
            xcnt  <= '0;
            ycnt  <= '0;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (x_fire) begin
            if (xcnt == X_LAST) state <= DRAIN;
            else xcnt <= xcnt + 1'b1;
          end
        end
        DRAIN: begin
          if (y_fire) begin
            if (ycnt == Y_LAST) begin
              state <= IDLE;
              grant <= '0;
              busy  <= 1'b0;
              ptr   <= (gidx == G_LAST) ? '0 : gidx + 1'b1;
            end else begin
              ycnt <= ycnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
